// File: rtl/bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter for the Life generation/population display.
// Digits and overflow update only on completion, so the display mux never sees partial values.
module bcd_converter #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(9999);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, next_state;
  logic [BIN_W-1:0] operand;
  logic [15:0]      scratch;
  logic [15:0]      scratch_adj;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             in_range_over;

  function automatic logic [3:0] add3_nibble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [15:0] add3_all(input logic [15:0] s);
    return {add3_nibble(s[15:12]), add3_nibble(s[11:8]),
            add3_nibble(s[7:4]),   add3_nibble(s[3:0])};
  endfunction

  // Only a 14-bit input can exceed 9999; narrower widths never clamp.
  assign in_range_over = ({{(32-BIN_W){1'b0}}, bin_in} > 32'd9999);
  assign scratch_adj   = add3_all(scratch);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (count == LAST_SHIFT) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      operand  <= '0;
      scratch  <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digit1   <= '0;
      digit2   <= '0;
      digit3   <= '0;
      digit4   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand <= in_range_over ? MAX_VAL : bin_in;
            ovf     <= in_range_over;
            scratch <= '0;
            count   <= '0;
          end
        end
        SHIFT: begin
          scratch <= {scratch_adj[14:0], operand[BIN_W-1]};
          operand <= {operand[BIN_W-2:0], 1'b0};
          count   <= count + 1'b1;
        end
        DONE: begin
          digit1   <= scratch[3:0];
          digit2   <= scratch[7:4];
          digit3   <= scratch[11:8];
          digit4   <= scratch[15:12];
          overflow <= ovf;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter: a cycle model predicts busy/done timing, a queue of expected
// results is filled at each accepting edge and drained whenever the converter signals done.
module tb_bcd_converter;

  localparam int BIN_W = 14;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [BIN_W-1:0] bin_in;
  logic             start;
  logic             busy, done, overflow;
  logic [3:0]       digit1, digit2, digit3, digit4;

  int checks   = 0;
  int failures = 0;

  bcd_converter #(.BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .start(start),
    .busy(busy), .done(done), .overflow(overflow),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] expected_of(input int v);
    int c;
    logic [16:0] r;
    c = (v > 9999) ? 9999 : v;
    r[16]    = (v > 9999);
    r[15:12] = 4'((c / 1000) % 10);
    r[11:8]  = 4'((c / 100) % 10);
    r[7:4]   = 4'((c / 10) % 10);
    r[3:0]   = 4'(c % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference timing model and scoreboard, evaluated 1 time unit after each rising edge.
  logic [16:0] exp_q[$];
  logic [16:0] held;
  int          mcnt    = 0;
  logic        exp_done = 1'b0;
  logic        en_chk  = 1'b0;

  always @(posedge clk) begin
    logic             s_rst, s_start;
    logic [BIN_W-1:0] s_bin;
    s_rst = rst_n; s_start = start; s_bin = bin_in;
    #1;
    if (!s_rst) begin
      mcnt = 0; exp_done = 1'b0; exp_q.delete(); held = '0; en_chk = 1'b1;
    end else begin
      exp_done = 1'b0;
      if (mcnt == 0) begin
        if (s_start) begin
          exp_q.push_back(expected_of(int'(s_bin)));
          mcnt = 1;
        end
      end else if (mcnt == BIN_W + 1) begin
        exp_done = 1'b1;
        mcnt = 0;
      end else begin
        mcnt++;
      end
    end
    if (en_chk) begin
      check("done", {16'd0, done}, {16'd0, exp_done});
      check("busy", {16'd0, busy}, {16'd0, (mcnt >= 1 && mcnt <= BIN_W)});
      if (done === 1'b1) begin
        if (exp_q.size() == 0) check("done_unexpected", 17'd1, 17'd0);
        else held = exp_q.pop_front();
      end
      check("digits_ovf", {overflow, digit4, digit3, digit2, digit1}, held);
    end
  end

  task automatic convert(input int v);
    @(negedge clk); bin_in = BIN_W'(v); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (17) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bin_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    convert(0);
    convert(1234);
    convert(9999);
    convert(12000);
    convert(7);
    convert(16383);
    convert(10000);

    // A second request in the middle of a conversion must be ignored.
    @(negedge clk); bin_in = BIN_W'(4321); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    bin_in = BIN_W'(5555); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);

    // Reset partway through aborts the conversion.
    @(negedge clk); bin_in = BIN_W'(8765); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    convert(42);

    // Continuous start with a moving operand.
    start = 1'b1;
    for (int i = 0; i <= 200; i++) begin
      @(negedge clk); bin_in = BIN_W'(i);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); bin_in = BIN_W'($urandom_range(0, 16383));
    end
    start = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
